// File: rtl/axi_dram_pkg.sv
// Shared response codes, burst constants, FSM state enums and the burst-legality helper
// used by the AXI DRAM responder.
package axi_dram_pkg;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_2B    = 3'b001;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Only 16-bit INCR bursts are served; anything else is answered with SLVERR.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size != SIZE_2B);
    endfunction

endpackage

// File: rtl/axi_dram_mem.sv
// Word array behind the AXI DRAM responder: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module axi_dram_mem
    import axi_dram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_dram_slave.sv
// AXI slave DRAM responder with independent read and write burst engines.
// Define AXI_DRAM_SLAVE_RD_LATENCY_EN to insert RD_LAT wait cycles before the first read beat.
module axi_dram_slave
    import axi_dram_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096,
    parameter int RD_LAT     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [6:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [6:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int LEN_W  = 7;
    localparam int WAIT_W = 8;

    rd_state_t             r_state_q, r_state_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0]      rd_len_q, rd_len_d;
    logic [LEN_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  rd_err_q, rd_err_d;
    logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    wr_state_t             w_state_q, w_state_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0]      wr_len_q, wr_len_d;
    logic [LEN_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  wr_err_q, wr_err_d;
    logic                  wr_mis_q, wr_mis_d;
    logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we;

    logic unused_bits;
    assign unused_bits = ^{araddr[ADDR_WIDTH-1:IDX_W+1], araddr[0],
                           awaddr[ADDR_WIDTH-1:IDX_W+1], awaddr[0], (RD_LAT > 0)};

    // ---------------- read engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_err_q   <= 1'b0;
            rd_id_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            r_state_q  <= r_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_err_q   <= rd_err_d;
            rd_id_q    <= rd_id_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        rd_idx_d   = rd_idx_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rd_err_d   = rd_err_q;
        rd_id_d    = rd_id_q;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rd_idx_d = araddr[1 +: IDX_W];
                    rd_len_d = arlen;
                    rd_cnt_d = '0;
                    rd_err_d = burst_illegal(arburst, arsize);
                    rd_id_d  = arid;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
                    wait_cnt_d = '0;
                    r_state_d  = R_WAIT;
`else
                    r_state_d  = R_DATA;
`endif
                end
            end
            R_WAIT: begin
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
                if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) begin
                    r_state_d = R_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`else
                r_state_d = R_DATA;
`endif
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rd_cnt_q == rd_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Beat data is captured when a beat is first presented, so it stays frozen through a stall.
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rvalid_d && (rd_cnt_d == rd_len_d);
        rdata_d   = rdata_q;
        if (rvalid_d && !(rvalid_q && !rready)) begin
            rdata_d = mem_rdata;
        end
    end

    // ---------------- write engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            wr_idx_q  <= '0;
            wr_len_q  <= '0;
            wr_cnt_q  <= '0;
            wr_err_q  <= 1'b0;
            wr_mis_q  <= 1'b0;
            wr_id_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wr_idx_q  <= wr_idx_d;
            wr_len_q  <= wr_len_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_err_q  <= wr_err_d;
            wr_mis_q  <= wr_mis_d;
            wr_id_q   <= wr_id_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wr_idx_d  = wr_idx_q;
        wr_len_d  = wr_len_q;
        wr_cnt_d  = wr_cnt_q;
        wr_err_d  = wr_err_q;
        wr_mis_d  = wr_mis_q;
        wr_id_d   = wr_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wr_idx_d  = awaddr[1 +: IDX_W];
                    wr_len_d  = awlen;
                    wr_cnt_d  = '0;
                    wr_err_d  = burst_illegal(awburst, awsize);
                    wr_mis_d  = 1'b0;
                    wr_id_d   = awid;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // The beat count ends the burst; wlast is only audited.
                if (wvalid && wready_q) begin
                    if (wlast != (wr_cnt_q == wr_len_q)) begin
                        wr_mis_d = 1'b1;
                    end
                    if (wr_cnt_q == wr_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        mem_we    = wready_q && wvalid && !wr_err_q;
    end

    axi_dram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_idx_q),
        .wdata_i (wdata),
        .raddr_i (rd_idx_d),
        .rdata_o (mem_rdata)
    );

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rid     = rd_id_q;
    assign rresp   = rd_err_q ? SLVERR : OKAY;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = wr_id_q;
    assign bresp   = (wr_err_q || wr_mis_q) ? SLVERR : OKAY;

endmodule

// File: tb/tb_axi_dram_slave.sv
// Scoreboard bench for axi_dram_slave: directed and random AXI bursts against a word-array model.
// Builds with or without AXI_DRAM_SLAVE_RD_LATENCY_EN.
module tb_axi_dram_slave;

    localparam int ID_W   = 4;
    localparam int AW     = 32;
    localparam int DW     = 16;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 4;
    localparam int TO     = 2000;
`ifdef AXI_DRAM_SLAVE_RD_LATENCY_EN
    localparam int EXP_LAT = RD_LAT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic [ID_W-1:0] arid, awid, rid, bid;
    logic [AW-1:0]   araddr, awaddr;
    logic [6:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0]   rdata, wdata;

    axi_dram_slave #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0]   data;
        bit              known;
        logic [ID_W-1:0] id;
        logic            last;
        logic [1:0]      resp;
    } rbeat_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } bexp_t;

    rbeat_t        rexp[$];
    bexp_t         bexp[$];
    logic [DW-1:0] model [DEPTH];
    bit            known [DEPTH];
    logic [DW-1:0] wbuf  [128];

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out after %0d cycles", name, TO);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [AW-1:0] addr, input int b);
        return int'(((addr >> 1) + 32'(b)) % 32'(DEPTH));
    endfunction

    // Monitor: pops the scoreboard on every handshake and audits stall stability.
    bit            stallPrev = 0;
    logic [DW-1:0] sData;
    logic [ID_W-1:0] sId;
    logic          sLast;
    rbeat_t        mr;
    bexp_t         mb;

    always @(negedge clk) begin
        if (stallPrev) begin
            checkOutput("stall_rvalid", 32'(rvalid), 32'd1);
            checkOutput("stall_rdata", 32'(rdata), 32'(sData));
            checkOutput("stall_rid", 32'(rid), 32'(sId));
            checkOutput("stall_rlast", 32'(rlast), 32'(sLast));
        end
        stallPrev = rst_n && rvalid && !rready;
        sData = rdata;
        sId   = rid;
        sLast = rlast;
        if (rvalid && rready) begin
            if (rexp.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL r_unexpected: got beat id=%0h data=%0h, want none", rid, rdata);
            end else begin
                mr = rexp.pop_front();
                checkOutput("r_id", 32'(rid), 32'(mr.id));
                checkOutput("r_last", 32'(rlast), 32'(mr.last));
                checkOutput("r_resp", 32'(rresp), 32'(mr.resp));
                if (mr.known) checkOutput("r_data", 32'(rdata), 32'(mr.data));
            end
        end
        if (bvalid && bready) begin
            if (bexp.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL b_unexpected: got bid=%0h bresp=%0h, want none", bid, bresp);
            end else begin
                mb = bexp.pop_front();
                checkOutput("b_id", 32'(bid), 32'(mb.id));
                checkOutput("b_resp", 32'(bresp), 32'(mb.resp));
            end
        end
    end

    task automatic doWrite(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input int lastAt,
                           input bit gaps);
        bit    err;
        int    n;
        bexp_t e;
        err    = (burst != 2'b01) || (size != 3'b001);
        e.id   = id;
        e.resp = (err || lastAt != len) ? 2'b10 : 2'b00;
        bexp.push_back(e);
        if (!err) begin
            for (int b = 0; b <= len; b++) begin
                model[widx(addr, b)] = wbuf[b];
                known[widx(addr, b)] = 1'b1;
            end
        end
        awid = id; awaddr = addr; awlen = 7'(len); awburst = burst; awsize = size; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) failTimeout("aw_handshake");
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            wvalid = 1'b1; wdata = wbuf[b]; wlast = (b == lastAt);
            n = 0;
            @(negedge clk);
            while (!wready && n < TO) begin @(negedge clk); n++; end
            if (n >= TO) failTimeout("w_handshake");
            tick();
            wvalid = 1'b0; wlast = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) failTimeout("b_wait");
        tick();
        bready = 1'b0;
    endtask

    // mode 0: rready held high, 1: random rready, 2: rready dropped 3 cycles after beat 2
    task automatic doRead(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
        bit     err;
        int     n, hs, beat, stallLeft;
        rbeat_t e;
        err = (burst != 2'b01) || (size != 3'b001);
        for (int b = 0; b <= len; b++) begin
            e.data  = model[widx(addr, b)];
            e.known = known[widx(addr, b)];
            e.id    = id;
            e.last  = (b == len);
            e.resp  = err ? 2'b10 : 2'b00;
            rexp.push_back(e);
        end
        rready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        arid = id; araddr = addr; arlen = 7'(len); arburst = burst; arsize = size; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) failTimeout("ar_handshake");
        hs = cyc;
        tick();
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < TO) begin @(negedge clk); n++; end
        checkOutput("rd_latency", 32'(cyc - hs), 32'(EXP_LAT));
        beat = 0; stallLeft = 3; n = 0;
        while (beat <= len && n < TO) begin
            if (rvalid && rready) beat++;
            tick();
            if (mode == 1) rready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && beat == 2 && stallLeft > 0) begin rready = 1'b0; stallLeft--; end
            else rready = 1'b1;
            if (beat <= len) @(negedge clk);
            n++;
        end
        if (beat <= len) failTimeout("r_beats");
        rready = 1'b0;
    endtask

    task automatic applyStimulus();
        int idx, len, lastAt;
        logic [AW-1:0]   addr;
        logic [1:0]      burst;
        logic [2:0]      size;
        logic [ID_W-1:0] id;
        idx   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 8, DEPTH - 1))
                                            : int'($urandom_range(0, 255));
        addr  = AW'(idx * 2 + int'($urandom_range(0, 1)));
        len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 127)) : int'($urandom_range(0, 15));
        burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
        size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
        id    = ID_W'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b <= len; b++) wbuf[b] = DW'($urandom);
            lastAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len + 1)) : len;
            doWrite(id, addr, len, burst, size, lastAt, 1'b1);
        end else begin
            doRead(id, addr, len, burst, size, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_arready", 32'(arready), 0);
        checkOutput("rst_awready", 32'(awready), 0);
        checkOutput("rst_wready", 32'(wready), 0);
        checkOutput("rst_rvalid", 32'(rvalid), 0);
        checkOutput("rst_rlast", 32'(rlast), 0);
        checkOutput("rst_bvalid", 32'(bvalid), 0);
        checkOutput("rst_rresp", 32'(rresp), 0);
        checkOutput("rst_bresp", 32'(bresp), 0);
        checkOutput("rst_rid", 32'(rid), 0);
        checkOutput("rst_bid", 32'(bid), 0);
        checkOutput("rst_rdata", 32'(rdata), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arready_before_edge", 32'(arready), 0);
        checkOutput("awready_before_edge", 32'(awready), 0);
        @(negedge clk);
        checkOutput("arready_after_rst", 32'(arready), 1);
        checkOutput("awready_after_rst", 32'(awready), 1);
        tick();

        // Preload words 0x10..0x13, then the basic and stalled read-back
        for (int b = 0; b < 4; b++) wbuf[b] = DW'(b + 1);
        doWrite(4'd1, 32'h20, 3, 2'b01, 3'b001, 3, 1'b0);
        doRead(4'd5, 32'h20, 3, 2'b01, 3'b001, 0);
        doRead(4'd5, 32'h20, 3, 2'b01, 3'b001, 2);
        doRead(4'd4, 32'h21, 0, 2'b01, 3'b001, 0);

        // Wrap from the top word to word 0
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB;
        doWrite(4'd2, AW'(2 * DEPTH - 2), 1, 2'b01, 3'b001, 1, 1'b0);
        doRead(4'd6, AW'(2 * DEPTH - 2), 1, 2'b01, 3'b001, 0);
        doRead(4'd6, 32'h0, 0, 2'b01, 3'b001, 0);

        // Illegal bursts: writes suppressed, reads still return data
        wbuf[0] = 16'hFFFF;
        doWrite(4'd3, 32'h20, 0, 2'b00, 3'b001, 0, 1'b0);
        doWrite(4'd3, 32'h22, 0, 2'b01, 3'b010, 0, 1'b0);
        doRead(4'd7, 32'h20, 1, 2'b01, 3'b001, 0);
        doRead(4'd8, 32'h20, 3, 2'b10, 3'b001, 1);

        // Early wlast flags SLVERR but the beats still land
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
        doWrite(4'd9, 32'h100, 2, 2'b01, 3'b001, 0, 1'b0);
        doRead(4'd9, 32'h100, 2, 2'b01, 3'b001, 0);

        repeat (40) applyStimulus();

        // Reset while beat 2 of an 8-beat read is on the bus
        for (int b = 0; b < 8; b++) wbuf[b] = DW'(16'h50 + b);
        doWrite(4'd1, 32'h200, 7, 2'b01, 3'b001, 7, 1'b0);
        begin
            rbeat_t e;
            e.data = model[widx(32'h200, 0)]; e.known = known[widx(32'h200, 0)];
            e.id = 4'd3; e.last = 1'b0; e.resp = 2'b00;
            rexp.push_back(e);
        end
        rready = 1'b1;
        arid = 4'd3; araddr = 32'h200; arlen = 7'd7; arburst = 2'b01; arsize = 3'b001; arvalid = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!arready && n < TO) begin @(negedge clk); n++; end
            if (n >= TO) failTimeout("rst_ar_handshake");
            tick();
            arvalid = 1'b0;
            n = 0;
            @(negedge clk);
            while (!rvalid && n < TO) begin @(negedge clk); n++; end
            if (n >= TO) failTimeout("rst_first_beat");
        end
        tick();
        rready = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_rvalid", 32'(rvalid), 0);
        checkOutput("rst_mid_rlast", 32'(rlast), 0);
        checkOutput("rst_mid_arready", 32'(arready), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_arready_hold", 32'(arready), 0);
        @(negedge clk);
        checkOutput("rst_mid_arready_rise", 32'(arready), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_mid_no_rvalid", 32'(rvalid), 0);
            checkOutput("rst_mid_no_bvalid", 32'(bvalid), 0);
            @(negedge clk);
        end
        tick();

        wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
        doWrite(4'd10, 32'h40, 1, 2'b01, 3'b001, 1, 1'b1);
        doRead(4'd11, 32'h40, 1, 2'b01, 3'b001, 1);

        repeat (3) @(negedge clk);
        checkOutput("rexp_drained", 32'(rexp.size()), 0);
        checkOutput("bexp_drained", 32'(bexp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, want finish before 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
